// File: rtl/pipelined_decode_ctrl.sv
// pipelined_decode_ctrl
//   Registered decode/issue controller at the D->X boundary of the pipelined CPU.
//   It decodes the opcode/ALU-op pair into X-stage control. It also sequences the
//   multicycle mult/div unit through a two-state FSM (StIdle, StMdWait).
//   While in StMdWait the FSM stalls F/D, watches for completion, exceptions and
//   timeout, and reports exceptions and timeouts through rstatus (r30).
//
// Ports
//   clock, reset_n              rising-edge clock, asynchronous active-low reset
//   in_valid, opcode, alu_op    D-stage instruction
//   flush                       taken jump/branch in X: kill D and any pending mul/div
//   md_ready, md_exception      mult/div unit handshake (exception qualified by ready)
//   out_valid, ctrl_*           registered X-stage control
//   md_start, md_abort          1-cycle pulses to the mult/div unit
//   stall                       combinational, high for every StMdWait cycle
//   status_we, status_val       rstatus write (code zero-extended to STATUS_W)
module pipelined_decode_ctrl #(
  parameter int unsigned OPCODE_W   = 5,
  parameter int unsigned ALUOP_W    = 5,
  parameter int unsigned STATUS_W   = 32,
  parameter int unsigned MD_TIMEOUT = 40,
  parameter int unsigned ST_MUL     = 4,
  parameter int unsigned ST_DIV     = 5,
  parameter int unsigned ST_TMO     = 6
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_valid,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [ALUOP_W-1:0]  alu_op,
  input  logic                flush,
  input  logic                md_ready,
  input  logic                md_exception,
  output logic                out_valid,
  output logic [ALUOP_W-1:0]  ctrl_alu_op,
  output logic                ctrl_reg_we,
  output logic                ctrl_alu_imm,
  output logic                ctrl_ram_we,
  output logic                ctrl_rd_from_ram,
  output logic [2:0]          ctrl_flow,
  output logic                md_start,
  output logic                md_abort,
  output logic                stall,
  output logic                status_we,
  output logic [STATUS_W-1:0] status_val
);

  localparam int unsigned CNT_W = $clog2(MD_TIMEOUT);

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_JAL   = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_JR    = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_BLT   = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_SETX  = OPCODE_W'(21);
  localparam logic [OPCODE_W-1:0] OP_BEX   = OPCODE_W'(22);

  localparam logic [ALUOP_W-1:0] ALU_MUL = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] ALU_DIV = ALUOP_W'(7);

  localparam logic [2:0] FLOW_NONE = 3'd0;
  localparam logic [2:0] FLOW_J    = 3'd1;
  localparam logic [2:0] FLOW_JAL  = 3'd2;
  localparam logic [2:0] FLOW_JR   = 3'd3;
  localparam logic [2:0] FLOW_BNE  = 3'd4;
  localparam logic [2:0] FLOW_BLT  = 3'd5;
  localparam logic [2:0] FLOW_BEX  = 3'd6;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  typedef enum logic [0:0] {StIdle, StMdWait} state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]   counter_q, counter_d;
  logic [ALUOP_W-1:0] md_op_q, md_op_d;

  // Next values of the registered outputs
  logic                out_valid_d;
  logic [ALUOP_W-1:0]  ctrl_alu_op_d;
  logic                ctrl_reg_we_d;
  logic                ctrl_alu_imm_d;
  logic                ctrl_ram_we_d;
  logic                ctrl_rd_from_ram_d;
  logic [2:0]          ctrl_flow_d;
  logic                md_start_d;
  logic                md_abort_d;
  logic                status_we_d;
  logic [STATUS_W-1:0] status_val_d;

  // Single-cycle decode of the incoming instruction
  logic                is_md;
  logic                accept;
  logic                md_timeout;
  logic [ALUOP_W-1:0]  dec_alu_op;
  logic                dec_reg_we;
  logic                dec_alu_imm;
  logic                dec_ram_we;
  logic                dec_rd_from_ram;
  logic [2:0]          dec_flow;

  assign is_md      = (opcode == OP_RTYPE) && ((alu_op == ALU_MUL) || (alu_op == ALU_DIV));
  assign accept     = in_valid && !flush;
  assign md_timeout = (counter_q == CNT_LAST);

  always_comb begin
    dec_alu_op      = (opcode == OP_RTYPE) ? alu_op : '0;
    dec_reg_we      = 1'b0;
    dec_alu_imm     = 1'b0;
    dec_ram_we      = 1'b0;
    dec_rd_from_ram = 1'b0;
    dec_flow        = FLOW_NONE;
    case (opcode)
      OP_RTYPE: dec_reg_we = 1'b1;
      OP_J:     dec_flow   = FLOW_J;
      OP_BNE:   dec_flow   = FLOW_BNE;
      OP_JAL: begin
        dec_flow   = FLOW_JAL;
        dec_reg_we = 1'b1;  // link into r31
      end
      OP_JR:    dec_flow   = FLOW_JR;
      OP_ADDI: begin
        dec_reg_we  = 1'b1;
        dec_alu_imm = 1'b1;
      end
      OP_BLT:   dec_flow   = FLOW_BLT;
      OP_SW: begin
        dec_alu_imm = 1'b1;
        dec_ram_we  = 1'b1;
      end
      OP_LW: begin
        dec_reg_we      = 1'b1;
        dec_alu_imm     = 1'b1;
        dec_rd_from_ram = 1'b1;
      end
      OP_SETX:  dec_reg_we = 1'b1;  // writes r30
      OP_BEX:   dec_flow   = FLOW_BEX;
      default: ;  // unknown opcodes issue as NOP
    endcase
  end

  // FSM: state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept && is_md) begin
          state_d = StMdWait;
        end
      end
      StMdWait: begin
        if (flush || md_ready || md_timeout) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM: output logic (next values of the registered outputs)
  always_comb begin
    out_valid_d        = 1'b0;
    ctrl_alu_op_d      = '0;
    ctrl_reg_we_d      = 1'b0;
    ctrl_alu_imm_d     = 1'b0;
    ctrl_ram_we_d      = 1'b0;
    ctrl_rd_from_ram_d = 1'b0;
    ctrl_flow_d        = FLOW_NONE;
    md_start_d         = 1'b0;
    md_abort_d         = 1'b0;
    status_we_d        = 1'b0;
    status_val_d       = '0;
    md_op_d            = md_op_q;
    counter_d          = counter_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_md) begin
            md_start_d = 1'b1;
            md_op_d    = alu_op;
            counter_d  = '0;
          end else begin
            out_valid_d        = 1'b1;
            ctrl_alu_op_d      = dec_alu_op;
            ctrl_reg_we_d      = dec_reg_we;
            ctrl_alu_imm_d     = dec_alu_imm;
            ctrl_ram_we_d      = dec_ram_we;
            ctrl_rd_from_ram_d = dec_rd_from_ram;
            ctrl_flow_d        = dec_flow;
          end
        end
      end
      StMdWait: begin
        if (counter_q != CNT_SAT) begin
          counter_d = counter_q + 1'b1;
        end
        // flush beats completion, completion beats timeout
        if (flush) begin
          md_abort_d = 1'b1;
        end else if (md_ready) begin
          out_valid_d = 1'b1;
          if (md_exception) begin
            status_we_d  = 1'b1;
            status_val_d = (md_op_q == ALU_MUL) ? STATUS_W'(ST_MUL) : STATUS_W'(ST_DIV);
          end else begin
            ctrl_reg_we_d = 1'b1;
            ctrl_alu_op_d = md_op_q;
          end
        end else if (md_timeout) begin
          md_abort_d   = 1'b1;
          out_valid_d  = 1'b1;
          status_we_d  = 1'b1;
          status_val_d = STATUS_W'(ST_TMO);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      counter_q        <= '0;
      md_op_q          <= '0;
      out_valid        <= 1'b0;
      ctrl_alu_op      <= '0;
      ctrl_reg_we      <= 1'b0;
      ctrl_alu_imm     <= 1'b0;
      ctrl_ram_we      <= 1'b0;
      ctrl_rd_from_ram <= 1'b0;
      ctrl_flow        <= FLOW_NONE;
      md_start         <= 1'b0;
      md_abort         <= 1'b0;
      status_we        <= 1'b0;
      status_val       <= '0;
    end else begin
      counter_q        <= counter_d;
      md_op_q          <= md_op_d;
      out_valid        <= out_valid_d;
      ctrl_alu_op      <= ctrl_alu_op_d;
      ctrl_reg_we      <= ctrl_reg_we_d;
      ctrl_alu_imm     <= ctrl_alu_imm_d;
      ctrl_ram_we      <= ctrl_ram_we_d;
      ctrl_rd_from_ram <= ctrl_rd_from_ram_d;
      ctrl_flow        <= ctrl_flow_d;
      md_start         <= md_start_d;
      md_abort         <= md_abort_d;
      status_we        <= status_we_d;
      status_val       <= status_val_d;
    end
  end

  assign stall = (state_q == StMdWait);

endmodule

// File: tb/tb_pipelined_decode_ctrl.sv
// Directed testbench for pipelined_decode_ctrl with hand-computed expectations.
module tb_pipelined_decode_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [4:0]  opcode;
  logic [4:0]  alu_op;
  logic        flush;
  logic        md_ready;
  logic        md_exception;
  logic        out_valid;
  logic [4:0]  ctrl_alu_op;
  logic        ctrl_reg_we;
  logic        ctrl_alu_imm;
  logic        ctrl_ram_we;
  logic        ctrl_rd_from_ram;
  logic [2:0]  ctrl_flow;
  logic        md_start;
  logic        md_abort;
  logic        stall;
  logic        status_we;
  logic [31:0] status_val;

  int n_checks = 0;
  int n_errors = 0;
  int stall_cnt;

  pipelined_decode_ctrl dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .in_valid         (in_valid),
    .opcode           (opcode),
    .alu_op           (alu_op),
    .flush            (flush),
    .md_ready         (md_ready),
    .md_exception     (md_exception),
    .out_valid        (out_valid),
    .ctrl_alu_op      (ctrl_alu_op),
    .ctrl_reg_we      (ctrl_reg_we),
    .ctrl_alu_imm     (ctrl_alu_imm),
    .ctrl_ram_we      (ctrl_ram_we),
    .ctrl_rd_from_ram (ctrl_rd_from_ram),
    .ctrl_flow        (ctrl_flow),
    .md_start         (md_start),
    .md_abort         (md_abort),
    .stall            (stall),
    .status_we        (status_we),
    .status_val       (status_val)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [4:0] op, input logic [4:0] aop);
    in_valid = 1'b1;
    opcode   = op;
    alu_op   = aop;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    reset_n      = 1'b0;
    in_valid     = 1'b0;
    opcode       = '0;
    alu_op       = '0;
    flush        = 1'b0;
    md_ready     = 1'b0;
    md_exception = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_md_start", 32'(md_start), 32'd0);
    chk("rst_status_val", status_val, 32'd0);
    reset_n = 1'b1;
    tick();

    // addi: ALU op forced to add, immediate operand
    issue(5'd5, 5'd3);
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_reg_we", 32'(ctrl_reg_we), 32'd1);
    chk("addi_alu_imm", 32'(ctrl_alu_imm), 32'd1);
    chk("addi_alu_op", 32'(ctrl_alu_op), 32'd0);
    chk("addi_stall", 32'(stall), 32'd0);
    chk("addi_ram_we", 32'(ctrl_ram_we), 32'd0);

    // R-type add passes alu_op through
    issue(5'd0, 5'd2);
    chk("rtype_valid", 32'(out_valid), 32'd1);
    chk("rtype_alu_op", 32'(ctrl_alu_op), 32'd2);
    chk("rtype_reg_we", 32'(ctrl_reg_we), 32'd1);
    chk("rtype_alu_imm", 32'(ctrl_alu_imm), 32'd0);

    // mul completing in the 17th wait cycle
    issue(5'd0, 5'd6);
    chk("mul_start", 32'(md_start), 32'd1);
    chk("mul_start_nov", 32'(out_valid), 32'd0);
    chk("mul_stall", 32'(stall), 32'd1);
    stall_cnt = 1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 0) chk("mul_start_pulse", 32'(md_start), 32'd0);
      if (stall) stall_cnt++;
    end
    md_ready = 1'b1;
    tick();
    md_ready = 1'b0;
    chk("mul_stall_cycles", 32'(stall_cnt), 32'd17);
    chk("mul_done_stall", 32'(stall), 32'd0);
    chk("mul_done_valid", 32'(out_valid), 32'd1);
    chk("mul_done_reg_we", 32'(ctrl_reg_we), 32'd1);
    chk("mul_done_alu_op", 32'(ctrl_alu_op), 32'd6);
    chk("mul_done_status_we", 32'(status_we), 32'd0);
    tick();
    chk("mul_valid_pulse", 32'(out_valid), 32'd0);

    // div with exception
    issue(5'd0, 5'd7);
    chk("div_start", 32'(md_start), 32'd1);
    md_ready     = 1'b1;
    md_exception = 1'b1;
    tick();
    md_ready     = 1'b0;
    md_exception = 1'b0;
    chk("divx_valid", 32'(out_valid), 32'd1);
    chk("divx_reg_we", 32'(ctrl_reg_we), 32'd0);
    chk("divx_status_we", 32'(status_we), 32'd1);
    chk("divx_status_val", status_val, 32'd5);
    chk("divx_stall", 32'(stall), 32'd0);
    tick();
    chk("divx_status_pulse", 32'(status_we), 32'd0);

    // div timeout: 40 wait cycles then forced abort
    issue(5'd0, 5'd7);
    stall_cnt = 0;
    while (stall && stall_cnt < 100) begin
      stall_cnt++;
      tick();
    end
    chk("tmo_cycles", 32'(stall_cnt), 32'd40);
    chk("tmo_abort", 32'(md_abort), 32'd1);
    chk("tmo_valid", 32'(out_valid), 32'd1);
    chk("tmo_status_we", 32'(status_we), 32'd1);
    chk("tmo_status_val", status_val, 32'd6);
    tick();
    chk("tmo_abort_pulse", 32'(md_abort), 32'd0);

    // flush wins over md_ready
    issue(5'd0, 5'd6);
    tick();
    flush    = 1'b1;
    md_ready = 1'b1;
    tick();
    flush    = 1'b0;
    md_ready = 1'b0;
    chk("flush_abort", 32'(md_abort), 32'd1);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_status_we", 32'(status_we), 32'd0);
    chk("flush_stall", 32'(stall), 32'd0);

    // flush in IDLE kills the D instruction
    flush = 1'b1;
    issue(5'd5, 5'd0);
    flush = 1'b0;
    chk("idle_flush_valid", 32'(out_valid), 32'd0);

    // jal, bex, unknown opcode, sw
    issue(5'd3, 5'd0);
    chk("jal_flow", 32'(ctrl_flow), 32'd2);
    chk("jal_reg_we", 32'(ctrl_reg_we), 32'd1);
    issue(5'd22, 5'd0);
    chk("bex_flow", 32'(ctrl_flow), 32'd6);
    chk("bex_reg_we", 32'(ctrl_reg_we), 32'd0);
    issue(5'd13, 5'd9);
    chk("nop_valid", 32'(out_valid), 32'd1);
    chk("nop_reg_we", 32'(ctrl_reg_we), 32'd0);
    chk("nop_flow", 32'(ctrl_flow), 32'd0);
    chk("nop_alu_op", 32'(ctrl_alu_op), 32'd0);
    issue(5'd7, 5'd0);
    chk("sw_ram_we", 32'(ctrl_ram_we), 32'd1);
    chk("sw_alu_imm", 32'(ctrl_alu_imm), 32'd1);
    chk("sw_reg_we", 32'(ctrl_reg_we), 32'd0);

    // Asynchronous reset in the middle of a wait
    issue(5'd0, 5'd6);
    tick();
    tick();
    chk("pre_rst_stall", 32'(stall), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_start", 32'(md_start), 32'd0);
    tick();
    chk("arst_abort", 32'(md_abort), 32'd0);
    reset_n = 1'b1;
    tick();
    issue(5'd8, 5'd0);
    chk("lw_valid", 32'(out_valid), 32'd1);
    chk("lw_reg_we", 32'(ctrl_reg_we), 32'd1);
    chk("lw_alu_imm", 32'(ctrl_alu_imm), 32'd1);
    chk("lw_rd_ram", 32'(ctrl_rd_from_ram), 32'd1);
    chk("lw_abort", 32'(md_abort), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
